// File: rtl/uart_rx_core.sv
// 16x-oversampling UART receiver with a valid/ready holding register.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_core #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BRK    = 3'd5
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [2:0]       BIDX_LAST = 3'(DATA_BITS - 1);

    logic                 rx_meta_q, rxs_q, rxs_prev_q;
    logic [DIV_W-1:0]     div_cnt_q;
    logic [DIV_W-1:0]     dmax_s;
    logic                 tick_s;
    state_t               state_q, state_d;
    logic [3:0]           sc_q, sc_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 complete_s, ferr_s, sample_s;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;

`ifndef UART_RX_PARITY_EN
    logic unused_cfg_s;
    assign unused_cfg_s = parity_en ^ parity_odd;
`endif

    // A divisor of 0 behaves as 1; >= keeps the counter sane if the divisor shrinks.
    assign dmax_s   = (baud_div == {DIV_W{1'b0}}) ? DIV_ONE : baud_div;
    assign tick_s   = (div_cnt_q >= (dmax_s - DIV_ONE));
    assign sample_s = tick_s && (sc_q == 4'd15);

    // Input synchronizer and free-running oversample tick counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            div_cnt_q  <= {DIV_W{1'b0}};
        end else begin
            rx_meta_q  <= rxd;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            div_cnt_q  <= tick_s ? {DIV_W{1'b0}} : (div_cnt_q + DIV_ONE);
        end
    end

    // Frame decoder next-state logic.
    always_comb begin
        state_d    = state_q;
        sc_d       = tick_s ? (sc_q + 4'd1) : sc_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        complete_s = 1'b0;
        ferr_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    sc_d    = 4'd0;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s && (sc_q == 4'd7)) begin
                    if (!rxs_q) begin
                        sc_d      = 4'd0;
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (sample_s) begin
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == BIDX_LAST) begin
                        bit_idx_d = 3'd0;
                        perr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
                        state_d   = parity_en ? S_PARITY : S_STOP;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample_s) begin
                    perr_d  = rxs_q ^ (^shift_q) ^ parity_odd;
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (sample_s) begin
                    complete_s = 1'b1;
                    ferr_s     = !rxs_q;
                    state_d    = rxs_q ? S_IDLE : S_BRK;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BRK: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BRK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame decoder registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sc_q      <= 4'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= {DATA_BITS{1'b0}};
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sc_q      <= sc_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
        end
    end

    // Holding register: accept a new word unless an unconsumed one is still held.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        if (complete_s) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                rx_valid_d   = 1'b1;
                frame_err_d  = ferr_s;
                parity_err_d = perr_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q    <= {DATA_BITS{1'b0}};
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at baud_div=4 (64 clk per bit); parity
// expectations follow whether UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;

    localparam int BIT = 64;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        parity_en, parity_odd, rxd, rx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, frame_err, parity_err, overrun_err;

    int          cyc = 0;
    int          ovr_cnt = 0;
    logic [9:0]  words[$];
    int          wcyc[$];
    int          rd = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    uart_rx_core #(.DATA_BITS(8), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_en(parity_en),
        .parity_odd(parity_odd), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every handshaken word ({frame_err, parity_err, data}) and overrun pulses.
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            words.push_back({frame_err, parity_err, rx_data});
            wcyc.push_back(cyc);
        end
        if (overrun_err) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        tick_n(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (with_par) drive_bit(par);
        drive_bit(stop);
        rxd = 1'b1;
    endtask

    function automatic logic [9:0] next_word();
        logic [9:0] w;
        if (rd < words.size()) begin
            w = words[rd];
            rd++;
        end else begin
            w = 10'h3FF;
        end
        return w;
    endfunction

    initial begin
        int s;
        int lat;
        int ovr_base;
        bit found;

        rst_n = 1'b0; baud_div = 16'd4; parity_en = 1'b0; parity_odd = 1'b0;
        rxd = 1'b1; rx_ready = 1'b1;
        tick_n(5);
        chk("reset_outputs", {rx_data, rx_valid, frame_err, parity_err, overrun_err}, 32'd0);
        rst_n = 1'b1;
        tick_n(20);

        // Clean 8N1 frame with latency window around 9.5 bit times.
        s = cyc;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        tick_n(32);
        chk("a5_count", words.size() - rd, 32'd1);
        lat = (rd < wcyc.size()) ? (wcyc[rd] - s) : -1;
        chk("a5_word", next_word(), {2'b00, 8'hA5});
        chk("a5_latency", ((lat >= 600) && (lat <= 620)) ? 32'd1 : 32'd0, 32'd1);
        chk("a5_valid_dropped", rx_valid, 32'd0);

        // Even parity, 0x03 with parity bit 1 -> mismatch when parity is built in.
        parity_en = 1'b1; parity_odd = 1'b0;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        tick_n(32);
        chk("even_par_word", next_word(), {1'b0, PAR_ON, 8'h03});

        // Odd parity, same frame -> no mismatch.
        parity_odd = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        tick_n(32);
        chk("odd_par_word", next_word(), {2'b00, 8'h03});
        parity_en = 1'b0; parity_odd = 1'b0;

        // Stop bit low -> frame error.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        tick_n(32);
        chk("ferr_word", next_word(), {2'b10, 8'h55});

        // 40-bit-time break: one word of zeros with frame error, nothing more.
        rxd = 1'b0;
        tick_n(40 * BIT);
        chk("brk_count_low", words.size() - rd, 32'd1);
        chk("brk_word", next_word(), {2'b10, 8'h00});
        rxd = 1'b1;
        tick_n(2 * BIT);
        chk("brk_count_high", words.size() - rd, 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        tick_n(32);
        chk("post_brk_word", next_word(), {2'b00, 8'h5A});

        // Two-tick glitch on idle line: ignored, next frame still decodes.
        rxd = 1'b0;
        tick_n(8);
        rxd = 1'b1;
        tick_n(5 * BIT);
        chk("glitch_no_word", words.size() - rd, 32'd0);
        chk("glitch_no_valid", rx_valid, 32'd0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        tick_n(32);
        chk("post_glitch_word", next_word(), {2'b00, 8'h81});

        // Overrun: consumer stalled across two frames.
        rx_ready = 1'b0;
        ovr_base = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        tick_n(32);
        chk("ovr_first_valid", {rx_valid, rx_data}, {1'b1, 8'h11});
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        tick_n(32);
        chk("ovr_kept_word", {rx_valid, rx_data}, {1'b1, 8'h11});
        chk("ovr_pulses", ovr_cnt - ovr_base, 32'd1);
        rx_ready = 1'b1;
        tick_n(1);
        rx_ready = 1'b0;
        tick_n(1);
        chk("ovr_drain_word", next_word(), {2'b00, 8'h11});
        chk("ovr_valid_clear", rx_valid, 32'd0);

        // Ready asserted exactly in the second completion cycle: no overrun.
        ovr_base = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        tick_n(32);
        found = 1'b0;
        fork
            send_frame(8'h22, 1'b0, 1'b0, 1'b1);
            begin
                for (int k = 0; (k < 1000) && !found; k++) begin
                    if (dut.complete_s) begin
                        rx_ready = 1'b1;
                        found = 1'b1;
                        tick_n(1);
                        rx_ready = 1'b0;
                    end else begin
                        tick_n(1);
                    end
                end
            end
        join
        tick_n(32);
        chk("exact_found", found, 32'd1);
        chk("exact_loaded", {rx_valid, rx_data}, {1'b1, 8'h22});
        chk("exact_no_ovr", ovr_cnt - ovr_base, 32'd0);
        chk("exact_old_word", next_word(), {2'b00, 8'h11});
        rx_ready = 1'b1;
        tick_n(2);
        chk("exact_new_word", next_word(), {2'b00, 8'h22});

        // Reset during the 4th data bit while a word is held.
        rx_ready = 1'b0;
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        tick_n(32);
        chk("pre_rst_held", {rx_valid, rx_data}, {1'b1, 8'h7E});
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rxd = 1'b1;
        tick_n(BIT / 2);
        rst_n = 1'b0;
        tick_n(1);
        chk("midrst_outputs", {rx_data, rx_valid, frame_err, parity_err, overrun_err}, 32'd0);
        tick_n(4);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        tick_n(2 * BIT);
        chk("post_rst_no_word", words.size() - rd, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        tick_n(32);
        chk("post_rst_count", words.size() - rd, 32'd1);
        chk("post_rst_word", next_word(), {2'b00, 8'h3C});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Synthesizable UART receive core: the RTL stage behind the `uart_if` serial line. It oversamples the serial input `rxd` at 16x, decodes start/data/parity/stop framing, and presents each received byte to a downstream consumer through a valid/ready holding register. Frame, parity and overrun errors are reported with the byte. It is the DUT-side receiver that the UART VIP agent drives through `uart_if`.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8, LSB first on the line.
- `DIV_W`, default 16: width of `baud_div`.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `baud_div`, input, DIV_W: clocks per oversample tick. A value of 0 is treated as 1.
- `parity_en`, input, 1: a parity bit follows the data bits.
- `parity_odd`, input, 1: 1 selects odd parity, 0 selects even.
- `rxd`, input, 1: serial input, asynchronous to `clk`, idles high.
- `rx_data`, output, DATA_BITS: received byte.
- `rx_valid`, output, 1: `rx_data`, `frame_err` and `parity_err` are valid.
- `rx_ready`, input, 1: consumer accepts the word.
- `frame_err`, output, 1: stop bit sampled as 0. Qualified by `rx_valid`.
- `parity_err`, output, 1: parity mismatch. Qualified by `rx_valid`.
- `overrun_err`, output, 1: one-cycle pulse when a completed frame is dropped.

## Operation
- Input conditioning:
  - `rxd` passes through a 2-flop synchronizer; both flops reset to 1.
  - The FSM sees only the synchronized bit `rxs`.
- Tick generator:
  - Counter counts 0..max(baud_div,1)-1 and produces a one-clock `tick` at the terminal count.
  - The counter runs continuously.
  - A sample counter `sc[3:0]` advances on each `tick`.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK.
- IDLE:
  - A 1→0 transition on `rxs` clears `sc` and moves to START.
- START:
  - At `sc`=7 (mid start bit), `rxs`=0 → clear `sc`, bit index=0, go to DATA.
  - At `sc`=7, `rxs`=1 → false start, return to IDLE. No output, no error.
- DATA:
  - Sample `rxs` when `sc` wraps 15→0, i.e. every 16 ticks, at mid-bit. Shift LSB first.
  - After DATA_BITS samples, go to PARITY if `parity_en`, else STOP.
- PARITY:
  - Sample 16 ticks after the last data sample.
  - `perr` = sampled bit XOR (XOR of data bits) XOR `parity_odd`.
  - Go to STOP.
- STOP:
  - Sample 16 ticks later; `ferr` = !`rxs`.
  - Complete the frame (see handshake).
  - `ferr`=0 → IDLE.
  - `ferr`=1 → BRK.
- BRK:
  - Wait for `rxs`=1, then go to IDLE. This prevents a held-low line from retriggering.
- Handshake / holding register:
  - Completion loads `rx_data`, `frame_err` and `parity_err`, and sets `rx_valid`, if either `rx_valid`=0 or `rx_ready`=1 in that cycle.
  - Otherwise the new frame is dropped, the old word is kept unchanged, and `overrun_err` pulses for 1 cycle.
  - `rx_valid` clears on `rx_valid && rx_ready` when there is no simultaneous completion.
  - Completion and handshake in the same cycle: no overrun; the new word is loaded and `rx_valid` stays 1.
  - Outputs are stable while `rx_valid && !rx_ready`.
- Configuration inputs (`baud_div`, `parity_en`, `parity_odd`) may only change in IDLE. Behaviour for changes mid-frame is undefined.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun_err`=0; FSM=IDLE; all counters 0.
- Synchronizer latency: 2 clk.
- Bit period: 16·D clk, where D = max(baud_div,1).
- Stop sample: (16·(1+DATA_BITS+P)+8)·D clk after start-edge detection, within one tick of jitter, where P = `parity_en`.
- `rx_valid` rises on the clock after the stop sample.
- `rx_valid` may stay high indefinitely. `rx_ready` is allowed to be permanently high.
- Reset mid-frame: immediate return to the reset state. The partial frame is discarded and no error is flagged.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state and checker are compiled in, as described above.
- `UART_RX_PARITY_EN` undefined:
  - The PARITY state is removed.
  - `parity_en` and `parity_odd` are present but ignored; frames are always no-parity.
  - `parity_err` is tied to 0.

## Test plan
- **Clean frame:** D=4, 8N1, send 0xA5, `rx_ready`=1 → `rx_valid` for 1 clk with `rx_data`=0xA5 and no errors, ~9.5·64 clk after the start edge.
- **Parity:**
  - Even parity, send 0x03 with parity bit 1 → `rx_data`=0x03, `parity_err`=1.
  - Odd parity, send 0x03 with parity bit 1 → `parity_err`=0.
  - Rerun without `UART_RX_PARITY_EN` → `parity_err`=0 always.
- **Framing/break:**
  - Send 0x55 with stop bit 0 → `frame_err`=1.
  - Hold `rxd` low for 40 bit times → exactly one word delivered; no further frame until `rxd` returns high.
- **Glitch:** a 2-tick low pulse on idle `rxd` → no `rx_valid` and FSM back in IDLE.
- **Overrun:**
  - `rx_ready`=0, send 0x11 then 0x22 → `rx_data` stays 0x11 and `overrun_err` pulses once at the second stop sample.
  - Repeat with `rx_ready` asserted exactly at the second completion → 0x22 loaded, no overrun.
- **Reset mid-frame:** assert `rst_n`=0 during the 4th data bit, release, then send 0x3C → all outputs 0 during reset, and the only word delivered is 0x3C.
